adder_trojan_monitor: RTL and testbench

//  Runtime checker sitting on the output side of the 4-bit trojan_adder datapath.

---
 rtl/adder_mon_pkg.sv | 35 +++
 rtl/mismatch_log_fifo.sv | 67 ++++++
 rtl/adder_trojan_monitor.sv | 193 +++++++++++++++++++
 tb/tb_adder_trojan_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_mon_pkg.sv
// -----------------------------------------------------------------------------
// adder_mon_pkg
// Shared types and helpers for the adder_trojan_monitor block.
//   mon_state_t : monitor FSM states (MONITOR, ALARM, HALT)
//   txn_t       : one {a,b,sum} transaction at the reference adder width
//   golden_sum  : reference addition, computed one bit wider than the operands
// Configuration macro used by the block: MISMATCH_LOG_EN (mismatch log FIFO).
// -----------------------------------------------------------------------------
package adder_mon_pkg;

  // Reference width of the trojan_adder datapath.
  localparam int ADDER_W = 4;

  // Width at which golden_sum operates. Callers zero-extend narrower operands,
  // so any operand width up to GOLD_W is handled without truncation.
  localparam int GOLD_W = 32;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    ALARM   = 2'd1,
    HALT    = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic [ADDER_W-1:0] a;
    logic [ADDER_W-1:0] b;
    logic [ADDER_W:0]   sum;
  } txn_t;

  function automatic logic [GOLD_W:0] golden_sum(input logic [GOLD_W-1:0] op_a,
                                                input logic [GOLD_W-1:0] op_b);
    return {1'b0, op_a} + {1'b0, op_b};
  endfunction

endpackage

// File: rtl/mismatch_log_fifo.sv
// -----------------------------------------------------------------------------
// mismatch_log_fifo
// Small synchronous FIFO holding failing transactions. The head entry is
// presented on dout while empty is low (first-word fall-through).
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write request and data; ignored when full unless a pop
//                  happens in the same cycle
//   pop          : remove head entry; ignored when empty
//   dout         : head entry
//   full, empty  : occupancy flags
// DEPTH must be a power of two, 2 or more.
// -----------------------------------------------------------------------------
module mismatch_log_fifo #(
  parameter int DW    = 13,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DW-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]   wr_ptr_d, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adder_trojan_monitor.sv
// -----------------------------------------------------------------------------
// adder_trojan_monitor
// Runtime checker on the output side of the trojan_adder datapath. Accepted
// {a,b,sum} transactions are registered into a single check stage, compared
// with the golden sum one cycle later, counted, and the first failure is held.
// A mismatch raises a sticky alarm; with HALT_ON_ALARM the monitor also stops
// accepting transactions until clr.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid, in_ready      : transaction handshake
//   a, b, sum               : operands and adder result under test
//   clr                     : clear alarm, counters and first-fail capture
//   alarm, halted           : sticky mismatch flag, FSM in HALT
//   txn_cnt, mismatch_cnt   : saturating counters
//   first_valid/a/b/sum     : first failing transaction
//   log_rd, log_valid, log_data : mismatch log access
// Configuration: define MISMATCH_LOG_EN to build the LOG_DEPTH-entry mismatch
// log; otherwise log_valid/log_data are tied to 0 and log_rd is ignored.
// -----------------------------------------------------------------------------
module adder_trojan_monitor
  import adder_mon_pkg::*;
#(
  parameter int W             = ADDER_W,
  parameter int CNT_W         = 16,
  parameter int HALT_ON_ALARM = 1,
  parameter int LOG_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W:0]       sum,
  input  logic             clr,
  output logic             alarm,
  output logic             halted,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_valid,
  output logic [W-1:0]     first_a,
  output logic [W-1:0]     first_b,
  output logic [W:0]       first_sum,
  input  logic             log_rd,
  output logic             log_valid,
  output logic [3*W:0]     log_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic             HALT_EN = (HALT_ON_ALARM != 0);

  mon_state_t state_q, state_d;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [W:0]       s1_sum_q, s1_sum_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d, mis_cnt_q, mis_cnt_d;
  logic             first_valid_q, first_valid_d;
  logic [W-1:0]     first_a_q, first_a_d, first_b_q, first_b_d;
  logic [W:0]       first_sum_q, first_sum_d;

  logic accept;
  logic mismatch;

  assign accept = in_valid && in_ready;

  // Golden comparison at full package width so no carry is ever dropped.
  assign mismatch = s1_valid_q &&
                    ({{(GOLD_W - W){1'b0}}, s1_sum_q} !=
                     golden_sum({{(GOLD_W - W){1'b0}}, s1_a_q},
                                {{(GOLD_W - W){1'b0}}, s1_b_q}));

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    alarm    = 1'b0;
    halted   = 1'b0;
    if (clr) begin
      state_d = MONITOR;
    end else begin
      case (state_q)
        MONITOR: if (mismatch) state_d = HALT_EN ? HALT : ALARM;
        ALARM:   state_d = ALARM;
        HALT:    state_d = HALT;
        default: state_d = MONITOR;
      endcase
    end
    in_ready = !rst && !clr && (state_q != HALT);
    alarm    = (state_q != MONITOR);
    halted   = (state_q == HALT);
  end

  // Check stage, counters and first-failure capture.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_a_d        = s1_a_q;
    s1_b_d        = s1_b_q;
    s1_sum_d      = s1_sum_q;
    txn_cnt_d     = txn_cnt_q;
    mis_cnt_d     = mis_cnt_q;
    first_valid_d = first_valid_q;
    first_a_d     = first_a_q;
    first_b_d     = first_b_q;
    first_sum_d   = first_sum_q;
    if (clr) begin
      // Whatever sits in stage 1 is discarded and never counted.
      s1_valid_d    = 1'b0;
      txn_cnt_d     = '0;
      mis_cnt_d     = '0;
      first_valid_d = 1'b0;
    end else begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d   = a;
        s1_b_d   = b;
        s1_sum_d = sum;
      end
      if (s1_valid_q && (txn_cnt_q != CNT_MAX)) txn_cnt_d = txn_cnt_q + CNT_ONE;
      if (mismatch && (mis_cnt_q != CNT_MAX))   mis_cnt_d = mis_cnt_q + CNT_ONE;
      if (mismatch && !first_valid_q) begin
        first_valid_d = 1'b1;
        first_a_d     = s1_a_q;
        first_b_d     = s1_b_q;
        first_sum_d   = s1_sum_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MONITOR;
      s1_valid_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_sum_q      <= '0;
      txn_cnt_q     <= '0;
      mis_cnt_q     <= '0;
      first_valid_q <= 1'b0;
      first_a_q     <= '0;
      first_b_q     <= '0;
      first_sum_q   <= '0;
    end else begin
      state_q       <= state_d;
      s1_valid_q    <= s1_valid_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_sum_q      <= s1_sum_d;
      txn_cnt_q     <= txn_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
      first_valid_q <= first_valid_d;
      first_a_q     <= first_a_d;
      first_b_q     <= first_b_d;
      first_sum_q   <= first_sum_d;
    end
  end

  assign txn_cnt      = txn_cnt_q;
  assign mismatch_cnt = mis_cnt_q;
  assign first_valid  = first_valid_q;
  assign first_a      = first_a_q;
  assign first_b      = first_b_q;
  assign first_sum    = first_sum_q;

`ifdef MISMATCH_LOG_EN
  logic log_full, log_empty;

  // A mismatch cancelled by clr is not logged; a full log drops new entries
  // unless a pop makes room in the same cycle.
  mismatch_log_fifo #(
    .DW    (3 * W + 1),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk),
    .rst   (rst),
    .push  (mismatch && !clr && (!log_full || log_rd)),
    .pop   (log_rd),
    .din   ({s1_a_q, s1_b_q, s1_sum_q}),
    .dout  (log_data),
    .full  (log_full),
    .empty (log_empty)
  );

  assign log_valid = !log_empty;
`else
  logic unused_log_cfg;
  assign unused_log_cfg = log_rd ^ LOG_DEPTH[0];
  assign log_valid      = 1'b0;
  assign log_data       = '0;
`endif

endmodule

// File: tb/tb_adder_trojan_monitor.sv
// -----------------------------------------------------------------------------
// tb_adder_trojan_monitor
// Three monitor instances share one stimulus stream:
//   0: HALT_ON_ALARM=1, CNT_W=16
//   1: HALT_ON_ALARM=0, CNT_W=16
//   2: HALT_ON_ALARM=0, CNT_W=2
// Outputs are compared every cycle with a transaction-level reference model.
// Build with +define+MISMATCH_LOG_EN to exercise the mismatch log.
// -----------------------------------------------------------------------------
module tb_adder_trojan_monitor;
  import adder_mon_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, clr = 1'b0, in_valid = 1'b0, log_rd = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [4:0] sum = '0;

  logic        rdy [NI];
  logic        alm [NI];
  logic        hlt [NI];
  logic        fv  [NI];
  logic        lv  [NI];
  logic [15:0] tc  [NI];
  logic [15:0] mc  [NI];
  logic [3:0]  fa  [NI];
  logic [3:0]  fb  [NI];
  logic [4:0]  fs  [NI];
  logic [12:0] ld  [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = (gi == 2) ? 2 : 16;
    logic [CW-1:0] t_w, m_w;
    adder_trojan_monitor #(
      .W             (4),
      .CNT_W         (CW),
      .HALT_ON_ALARM ((gi == 0) ? 1 : 0),
      .LOG_DEPTH     (4)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (rdy[gi]),
      .a            (a),
      .b            (b),
      .sum          (sum),
      .clr          (clr),
      .alarm        (alm[gi]),
      .halted       (hlt[gi]),
      .txn_cnt      (t_w),
      .mismatch_cnt (m_w),
      .first_valid  (fv[gi]),
      .first_a      (fa[gi]),
      .first_b      (fb[gi]),
      .first_sum    (fs[gi]),
      .log_rd       (log_rd),
      .log_valid    (lv[gi]),
      .log_data     (ld[gi])
    );
    assign tc[gi] = 16'(t_w);
    assign mc[gi] = 16'(m_w);
  end

  // ---------------- reference model ----------------
  int   cmax  [NI] = '{65535, 65535, 3};
  bit   hmode [NI] = '{1'b1, 1'b0, 1'b0};
  int   m_txn [NI];
  int   m_mis [NI];
  bit   m_alarm [NI];
  bit   m_halt  [NI];
  bit   m_fv    [NI];
  bit   m_rdy   [NI];
  txn_t m_first [NI];
  bit   p_v     [NI];
  txn_t p_t     [NI];
  txn_t m_log   [NI][$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit   do_pop;
    txn_t cur;
    cur.a   = a;
    cur.b   = b;
    cur.sum = sum;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_txn[k] = 0; m_mis[k] = 0; m_alarm[k] = 0; m_halt[k] = 0;
        m_fv[k] = 0; p_v[k] = 0;
        m_log[k].delete();
      end else begin
        do_pop = log_rd && (m_log[k].size() > 0);
`ifdef MISMATCH_LOG_EN
        if (do_pop) void'(m_log[k].pop_front());
`endif
        if (clr) begin
          m_txn[k] = 0; m_mis[k] = 0; m_alarm[k] = 0; m_halt[k] = 0;
          m_fv[k] = 0; p_v[k] = 0;
        end else begin
          if (p_v[k]) begin
            if (m_txn[k] < cmax[k]) m_txn[k]++;
            if (int'(p_t[k].sum) != int'(p_t[k].a) + int'(p_t[k].b)) begin
              if (m_mis[k] < cmax[k]) m_mis[k]++;
              if (!m_fv[k]) begin
                m_fv[k]    = 1;
                m_first[k] = p_t[k];
              end
              if (!m_alarm[k]) begin
                m_alarm[k] = 1;
                m_halt[k]  = hmode[k];
              end
`ifdef MISMATCH_LOG_EN
              if (m_log[k].size() < 4) m_log[k].push_back(p_t[k]);
`endif
            end
          end
          p_v[k] = m_rdy[k] && in_valid;
          p_t[k] = cur;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("alarm%0d", k),  32'(alm[k]), 32'(m_alarm[k]));
      check($sformatf("halted%0d", k), 32'(hlt[k]), 32'(m_halt[k]));
      check($sformatf("txn%0d", k),    32'(tc[k]),  32'(m_txn[k]));
      check($sformatf("mis%0d", k),    32'(mc[k]),  32'(m_mis[k]));
      check($sformatf("fvalid%0d", k), 32'(fv[k]),  32'(m_fv[k]));
      if (m_fv[k])
        check($sformatf("first%0d", k), 32'({fa[k], fb[k], fs[k]}), 32'(m_first[k]));
`ifdef MISMATCH_LOG_EN
      check($sformatf("logv%0d", k), 32'(lv[k]), 32'(m_log[k].size() > 0));
      if (m_log[k].size() > 0)
        check($sformatf("logd%0d", k), 32'(ld[k]), 32'(m_log[k][0]));
`else
      check($sformatf("logv%0d", k), 32'(lv[k]), 32'd0);
      check($sformatf("logd%0d", k), 32'(ld[k]), 32'd0);
`endif
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check state after.
  task automatic cycle();
    #1;
    for (int k = 0; k < NI; k++) begin
      m_rdy[k] = !rst && !clr && !m_halt[k];
      check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_rdy[k]));
    end
    if (in_valid) $display("[TB] txn a=%0d b=%0d sum=%0d rst=%0b clr=%0b", a, b, sum, rst, clr);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic send(input logic [3:0] va, input logic [3:0] vb, input logic [4:0] vs);
    in_valid = 1'b1; a = va; b = vb; sum = vs;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cycle(); clr = 1'b0;
  endtask

  initial begin
    // Reset, then the reset state with rst released.
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    cycle();
    for (int k = 0; k < NI; k++) check($sformatf("rst_txn%0d", k), 32'(tc[k]), 32'd0);

    // Good transaction.
    send(4'd3, 4'd2, 5'd5); cycle();
    check("t1_txn", 32'(tc[1]), 32'd1);
    check("t1_alarm", 32'(alm[1]), 32'd0);

    // Good then trojan-fired vector.
    send(4'd5, 4'd7, 5'd12); send(4'd8, 4'd1, 5'd17); cycle();
    check("t2_mis", 32'(mc[0]), 32'd1);
    check("t2_first", 32'({fa[0], fb[0], fs[0]}), 32'({4'd8, 4'd1, 5'd17}));
    check("t2_halted", 32'(hlt[0]), 32'd1);
    #1 check("t2_ready", 32'(rdy[0]), 32'd0);
    check("t2_alarm1", 32'(alm[1]), 32'd1);

    // Back-to-back mismatches; first capture must hold.
    pulse_clr();
    send(4'd8, 4'd1, 5'd17); send(4'd2, 4'd2, 5'd9); cycle();
    check("t3_mis", 32'(mc[1]), 32'd2);
    check("t3_first", 32'({fa[1], fb[1], fs[1]}), 32'({4'd8, 4'd1, 5'd17}));

    // clr while stage 1 holds a mismatch.
    pulse_clr();
    send(4'd8, 4'd1, 5'd17);
    pulse_clr();
    check("t4_mis", 32'(mc[1]), 32'd0);
    check("t4_txn", 32'(tc[1]), 32'd0);
    check("t4_alarm", 32'(alm[0]), 32'd0);
    #1 check("t4_ready", 32'(rdy[0]), 32'd1);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) send(4'd1, 4'(i), 5'(i + 1));
    cycle();
    check("t5_sat", 32'(tc[2]), 32'd3);
    check("t5_full", 32'(tc[1]), 32'd5);

`ifdef MISMATCH_LOG_EN
    // Five mismatches into a four-entry log, then drain in order.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i + 1), 4'd1, 5'd0);
    cycle();
    check("t6_mis", 32'(mc[1]), 32'd5);
    check("t6_lv", 32'(lv[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_pop%0d", i), 32'(ld[1]), 32'({4'(i + 1), 4'd1, 5'd0}));
      log_rd = 1'b1; cycle(); log_rd = 1'b0;
    end
    check("t6_empty", 32'(lv[1]), 32'd0);
`endif

    // Randomized traffic including mid-stream clr/rst.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) sum = 5'($urandom_range(0, 31));
      else                           sum = {1'b0, a} + {1'b0, b};
      clr    = ($urandom_range(0, 39) == 0);
      rst    = ($urandom_range(0, 99) == 0);
      log_rd = ($urandom_range(0, 2) == 0);
      cycle();
    end
    in_valid = 1'b0; clr = 1'b0; rst = 1'b0; log_rd = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
